// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Two-requester arbiter and wait-state sequencer for the shared single-port
// async_mem. Port 0 is the multi-cycle MIPS core and port 1 is a secondary
// master (loader, debug or DMA engine). A granted transaction owns the
// memory interface for READ_WAIT cycles (read) or one cycle (write). The
// granted port then gets a one-cycle ack. For a read, the registered read
// data is valid on the ack cycle.
//
// Parameters
//   READ_WAIT      cycles mem_read is held before read data is captured (>= 1)
//
// Ports
//   clk            system clock, all state on posedge
//   reset          synchronous, active-high
//   m0_* / m1_*    requester ports: req, write, addr, wdata in; rdata, ack out
//   busy           high whenever a transaction is in flight
//   mem_read       async_mem read strobe (held for the whole read window)
//   mem_write      async_mem write strobe (one cycle)
//   mem_addr       latched address, zero outside the access window
//   mem_write_data latched write data, holds its last value
//   mem_read_data  combinational read data from async_mem
module mem_port_arbiter #(
    parameter int READ_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int CW = $clog2(READ_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t        state;
    state_t        state_d;

    logic          last;       // port granted most recently
    logic          grant;      // port owning the current transaction
    logic          is_write;
    logic [31:0]   addr_q;
    logic [CW-1:0] cnt;        // access cycles remaining, including this one

    logic          any_req;
    logic          sel;
    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          final_cycle;

    // Arbitration, next-state and memory-side outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block leaves one unassigned and no latch is inferred.
        state_d     = state;
        any_req     = m0_req | m1_req;
        // On contention the port that did not win last time goes next.
        // Otherwise the only requester wins.
        sel         = (m0_req && m1_req) ? ~last : m1_req;
        sel_write   = sel ? m1_write : m0_write;
        sel_addr    = sel ? m1_addr  : m0_addr;
        sel_wdata   = sel ? m1_wdata : m0_wdata;
        final_cycle = (cnt == CW'(1));

        case (state)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (final_cycle) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy      = (state != IDLE);
        mem_read  = (state == ACCESS) && !is_write;
        mem_write = (state == ACCESS) &&  is_write;
        mem_addr  = (state == ACCESS) ? addr_q : '0;
        m0_ack    = (state == ACK) && !grant;
        m1_ack    = (state == ACK) &&  grant;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every flop samples the
        // values from before this edge regardless of statement order.
        if (reset) begin
            state          <= IDLE;
            last           <= 1'b1;      // port 0 wins the first contention
            grant          <= 1'b0;
            is_write       <= 1'b0;
            addr_q         <= '0;
            cnt            <= '0;
            mem_write_data <= '0;
            // NOTE: the read-data holding registers are ordinary flops, not a
            // RAM, so they take a reset value like the rest of the state.
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant          <= sel;
                        last           <= sel;
                        is_write       <= sel_write;
                        addr_q         <= sel_addr;
                        mem_write_data <= sel_wdata;
                        cnt            <= sel_write ? CW'(1) : CW'(READ_WAIT);
                    end
                end
                ACCESS: begin
                    cnt <= cnt - CW'(1);
                    // The read strobe has been stable for READ_WAIT cycles
                    // by this edge, so the memory output has settled.
                    if (final_cycle && !is_write) begin
                        if (grant) m1_rdata <= mem_read_data;
                        else       m0_rdata <= mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural async_mem sits on
// the memory side. A transaction-level reference model predicts each
// round's grant order, access windows, ack cycles and read data from the
// arbitration rules and wait-state arithmetic. Cycle index j counts negedges
// after the requests are driven in an IDLE cycle.
module tb_mem_port_arbiter;

    localparam int READ_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] av_in [2];
    logic [31:0] dv_in [2];
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        busy, mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [1:0]  ack_v;

    mem_port_arbiter #(.READ_WAIT(READ_WAIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_req         (req[0]),
        .m0_write       (wr[0]),
        .m0_addr        (av_in[0]),
        .m0_wdata       (dv_in[0]),
        .m0_rdata       (m0_rdata),
        .m0_ack         (m0_ack),
        .m1_req         (req[1]),
        .m1_write       (wr[1]),
        .m1_addr        (av_in[1]),
        .m1_wdata       (dv_in[1]),
        .m1_rdata       (m1_rdata),
        .m1_ack         (m1_ack),
        .busy           (busy),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign ack_v = {m1_ack, m0_ack};

    // Behavioural async_mem: combinational read, write commits on posedge.
    logic [31:0] mem [256];
    logic [31:0] init_vals [256];
    logic        preload = 1'b0;

    assign mem_read_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_vals[i];
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_write_data;
        end
    end

    // Reference model state.
    logic        m_last;
    logic [31:0] m_mem [256];
    logic [31:0] m_rdata [2];

    int total = 0;
    int bad   = 0;

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_last     = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // One arbitration round: the ports in mask request at the same time in
    // an IDLE cycle, and each holds its request until its predicted ack.
    task automatic run_round(input string tag, input logic [1:0] mask,
                             input logic [1:0] w,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             output int ack_at0, output int ack_at1);
        int          first, second, n;
        int          wt [2];
        int          acc_lo [2];
        int          acc_hi [2];
        int          ack_j [2];
        logic [31:0] av [2];
        logic [31:0] dv [2];
        logic [1:0]  exp_ack;
        logic        exp_rd, exp_wr, exp_busy;
        logic [31:0] exp_addr, exp_wdata;

        ack_at0 = -1;
        ack_at1 = -1;
        av[0] = a0; av[1] = a1;
        dv[0] = d0; dv[1] = d1;
        for (int p = 0; p < 2; p++) begin
            wt[p]     = w[p] ? 1 : READ_WAIT;
            acc_lo[p] = -100;
            acc_hi[p] = -100;
            ack_j[p]  = -100;
        end
        if (mask == 2'b11) first = m_last ? 0 : 1;
        else               first = mask[1] ? 1 : 0;
        second = 1 - first;
        acc_lo[first] = 1;
        acc_hi[first] = wt[first];
        ack_j[first]  = wt[first] + 1;
        n = ack_j[first];
        if (mask == 2'b11) begin
            // The second port is sampled in the IDLE cycle after the first ack.
            acc_lo[second] = wt[first] + 3;
            acc_hi[second] = wt[first] + 2 + wt[second];
            ack_j[second]  = acc_hi[second] + 1;
            n = ack_j[second];
        end

        @(negedge clk);
        total++;
        if ({busy, mem_read, mem_write, ack_v} !== 5'b0) begin
            bad++;
            $display("FAIL %s idle_before got=%b exp=00000", tag,
                     {busy, mem_read, mem_write, ack_v});
        end
        av_in[0] = a0; av_in[1] = a1;
        dv_in[0] = d0; dv_in[1] = d1;
        wr  = w;
        req = mask;

        for (int j = 1; j <= n + 1; j++) begin
            @(negedge clk);
            exp_ack   = 2'b00;
            exp_rd    = 1'b0;
            exp_wr    = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
            exp_busy  = (j <= n) && !(mask == 2'b11 && j == wt[first] + 2);
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    if (j == ack_j[p]) begin
                        exp_ack[p] = 1'b1;
                        if (w[p]) m_mem[av[p][9:2]] = dv[p];
                        else      m_rdata[p] = m_mem[av[p][9:2]];
                    end
                    if (j >= acc_lo[p] && j <= acc_hi[p]) begin
                        exp_rd    = !w[p];
                        exp_wr    = w[p];
                        exp_addr  = av[p];
                        exp_wdata = dv[p];
                    end
                end
            end

            if (ack_v[0] && ack_at0 < 0) ack_at0 = j;
            if (ack_v[1] && ack_at1 < 0) ack_at1 = j;

            total++;
            if (ack_v !== exp_ack) begin
                bad++;
                $display("FAIL %s ack j=%0d got=%b exp=%b", tag, j, ack_v, exp_ack);
            end
            total++;
            if ({mem_read, mem_write, mem_addr} !== {exp_rd, exp_wr, exp_addr}) begin
                bad++;
                $display("FAIL %s mem_ctrl j=%0d got rd=%b wr=%b addr=%h exp rd=%b wr=%b addr=%h",
                         tag, j, mem_read, mem_write, mem_addr, exp_rd, exp_wr, exp_addr);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy j=%0d got=%b exp=%b", tag, j, busy, exp_busy);
            end
            total++;
            if ({m1_rdata, m0_rdata} !== {m_rdata[1], m_rdata[0]}) begin
                bad++;
                $display("FAIL %s rdata j=%0d got=%h/%h exp=%h/%h", tag, j,
                         m0_rdata, m1_rdata, m_rdata[0], m_rdata[1]);
            end
            if (exp_wr) begin
                total++;
                if (mem_write_data !== exp_wdata) begin
                    bad++;
                    $display("FAIL %s wdata j=%0d got=%h exp=%h", tag, j,
                             mem_write_data, exp_wdata);
                end
            end

            if (mask[0] && j == ack_j[0]) req[0] = 1'b0;
            if (mask[1] && j == ack_j[1]) req[1] = 1'b0;
        end
        m_last = (mask == 2'b11) ? (second == 1) : (first == 1);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({busy, mem_read, mem_write, ack_v} !== 5'b0) begin
            bad++;
            $display("FAIL reset ctrl got=%b exp=00000", {busy, mem_read, mem_write, ack_v});
        end
        total++;
        if ({mem_addr, mem_write_data} !== 64'h0) begin
            bad++;
            $display("FAIL reset mem_bus got addr=%h wdata=%h exp 0", mem_addr, mem_write_data);
        end
        total++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset rdata got=%h/%h exp 0", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_single_read();
        int a0, a1;
        run_round("single_read", 2'b01, 2'b00, 32'h14, 32'h0, 32'h0, 32'h0, a0, a1);
        total++;
        if (a0 !== READ_WAIT + 1 || a1 !== -1) begin
            bad++;
            $display("FAIL single_read ack_time got=%0d/%0d exp=%0d/-1", a0, a1, READ_WAIT + 1);
        end
        total++;
        if (m0_rdata !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL single_read data got=%h exp=cafe0001", m0_rdata);
        end
    endtask

    task automatic test_single_write();
        int a0, a1;
        run_round("single_write", 2'b10, 2'b10, 32'h0, 32'hC8, 32'h0, 32'h37, a0, a1);
        total++;
        if (a1 !== 2 || a0 !== -1) begin
            bad++;
            $display("FAIL single_write ack_time got=%0d/%0d exp=-1/2", a0, a1);
        end
        run_round("write_readback", 2'b01, 2'b00, 32'hC8, 32'h0, 32'h0, 32'h0, a0, a1);
        total++;
        if (m0_rdata !== 32'h37) begin
            bad++;
            $display("FAIL write_readback data got=%h exp=00000037", m0_rdata);
        end
    endtask

    task automatic test_contention();
        int a0, a1;
        do_reset();
        run_round("contention", 2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, a0, a1);
        total++;
        if (a0 !== READ_WAIT + 1 || (a1 - a0) !== READ_WAIT + 2) begin
            bad++;
            $display("FAIL contention order got ack0=%0d ack1=%0d exp ack0=%0d gap=%0d",
                     a0, a1, READ_WAIT + 1, READ_WAIT + 2);
        end
    endtask

    task automatic test_fairness();
        int   acks;
        int   start;
        int   exp_port;
        int   budget;
        logic [31:0] fa [2];
        fa[0] = 32'h20;
        fa[1] = 32'h24;
        acks  = 0;
        start = m_last ? 0 : 1;
        budget = 6 * (READ_WAIT + 2) + 10;
        @(negedge clk);
        av_in[0] = fa[0]; av_in[1] = fa[1];
        wr  = 2'b00;
        req = 2'b11;
        for (int j = 1; j <= budget && acks < 6; j++) begin
            @(negedge clk);
            if (ack_v != 2'b00) begin
                exp_port = start ^ (acks % 2);
                total++;
                if (ack_v !== (2'b01 << exp_port) ||
                    j !== (READ_WAIT + 1) + acks * (READ_WAIT + 2)) begin
                    bad++;
                    $display("FAIL fairness ack%0d got=%b at j=%0d exp port%0d at j=%0d",
                             acks, ack_v, j, exp_port,
                             (READ_WAIT + 1) + acks * (READ_WAIT + 2));
                end
                m_rdata[exp_port] = m_mem[fa[exp_port][9:2]];
                m_last = (exp_port == 1);
                total++;
                if ({m1_rdata, m0_rdata} !== {m_rdata[1], m_rdata[0]}) begin
                    bad++;
                    $display("FAIL fairness rdata%0d got=%h/%h exp=%h/%h", acks,
                             m0_rdata, m1_rdata, m_rdata[0], m_rdata[1]);
                end
                acks++;
                if (acks == 6) req = 2'b00;
            end
        end
        req = 2'b00;
        total++;
        if (acks !== 6) begin
            bad++;
            $display("FAIL fairness count got=%0d exp=6", acks);
        end
        // Flush: if the DUT went astray, a reset puts bench and model back in step.
        if (acks != 6) do_reset();
    endtask

    task automatic test_reset_mid_read();
        int a0, a1;
        int stray;
        @(negedge clk);
        av_in[0] = 32'h30;
        wr  = 2'b00;
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, busy, ack_v} !== 5'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid ctrl got=%b addr=%h exp 0",
                     {mem_read, mem_write, busy, ack_v}, mem_addr);
        end
        total++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid rdata got=%h/%h exp 0", m0_rdata, m1_rdata);
        end
        reset = 1'b0;
        req   = 2'b00;
        m_last     = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        stray = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (ack_v != 2'b00) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL reset_mid stray_ack got=%0d exp=0", stray);
        end
        run_round("after_reset", 2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 32'h0, a0, a1);
    endtask

    task automatic test_back_to_back();
        int acks;
        int at [2];
        at[0] = -1;
        at[1] = -1;
        acks  = 0;
        @(negedge clk);
        av_in[0] = 32'h40;
        wr  = 2'b00;
        req = 2'b01;
        for (int j = 1; j <= 2 * READ_WAIT + 6; j++) begin
            @(negedge clk);
            if (ack_v != 2'b00) begin
                total++;
                if (ack_v !== 2'b01) begin
                    bad++;
                    $display("FAIL back_to_back port got=%b exp=01", ack_v);
                end
                if (acks < 2) begin
                    at[acks] = j;
                    total++;
                    if (m0_rdata !== m_mem[(acks == 0) ? 8'h10 : 8'h11]) begin
                        bad++;
                        $display("FAIL back_to_back rdata%0d got=%h exp=%h", acks,
                                 m0_rdata, m_mem[(acks == 0) ? 8'h10 : 8'h11]);
                    end
                end
                acks++;
                // Keep req high across the ack; only the address changes.
                if (acks == 1) av_in[0] = 32'h44;
                else           req = 2'b00;
            end
        end
        req = 2'b00;
        total++;
        if (acks !== 2 || at[0] !== READ_WAIT + 1 || at[1] !== 2 * READ_WAIT + 3) begin
            bad++;
            $display("FAIL back_to_back timing got n=%0d at=%0d,%0d exp n=2 at=%0d,%0d",
                     acks, at[0], at[1], READ_WAIT + 1, 2 * READ_WAIT + 3);
        end
        m_rdata[0] = m_mem[8'h11];
        m_last = 1'b0;
    endtask

    task automatic test_random();
        int          a0, a1;
        logic [1:0]  mask, w;
        logic [31:0] ad0, ad1, d0, d1;
        for (int r = 0; r < 30; r++) begin
            mask = 2'($urandom_range(1, 3));
            w    = 2'($urandom);
            ad0  = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
            ad1  = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
            d0   = $urandom;
            d1   = $urandom;
            run_round($sformatf("random%0d", r), mask, w, ad0, ad1, d0, d1, a0, a1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        wr    = 2'b00;
        av_in[0] = '0; av_in[1] = '0;
        dv_in[0] = '0; dv_in[1] = '0;
        for (int i = 0; i < 256; i++) begin
            init_vals[i] = $urandom;
            m_mem[i]     = init_vals[i];
        end
        init_vals[5] = 32'hCAFE0001;
        m_mem[5]     = 32'hCAFE0001;
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;

        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_fairness();
        test_reset_mid_read();
        test_back_to_back();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
